// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port data memory with valid/ready requests, byte-lane writes,
// configurable read latency, out-of-range error responses and a post-reset clear.
module mem_ctrl #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 16,
  parameter int DEPTH          = 256,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);
  localparam int BW = DATA_W / 8;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {CLEAR, IDLE, RD_WAIT} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IW-1:0] ptr, idx;
  logic [1:0] cnt;
  logic [DATA_W-1:0] hold, word;
  logic hold_err, oor, acc;
  assign idx  = req_addr[IW-1:0];
  assign oor  = {1'b0, req_addr} >= (ADDR_W+1)'(DEPTH);
  assign acc  = rst_n && req_valid && req_ready;
  assign word = oor ? '0 : mem[idx];
  always_ff @(posedge clk)
    if (rst_n && state == CLEAR) mem[ptr] <= '0;
    else if (acc && req_we && !oor)
      for (int i = 0; i < BW; i++)
        if (req_be[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
  // The last RD_WAIT edge returns to IDLE while raising rsp_valid, so the response
  // cycle already presents req_ready = 1 and a new request can be taken in it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= CLEAR_ON_RESET != 0 ? CLEAR : IDLE;
      ptr       <= '0;
      cnt       <= '0;
      hold      <= '0;
      hold_err  <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= CLEAR_ON_RESET != 0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        CLEAR: begin
          ptr <= ptr + IW'(1);
          if (ptr == IW'(DEPTH - 1)) begin
            state     <= IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        IDLE: begin
          req_ready <= 1'b1;
          if (acc && req_we) begin
            rsp_valid <= 1'b1;
            rsp_err   <= oor;
          end else if (acc && RD_LAT == 1) begin
            rsp_valid <= 1'b1;
            rsp_err   <= oor;
            rsp_rdata <= word;
          end else if (acc) begin
            state     <= RD_WAIT;
            cnt       <= 2'(RD_LAT - 1);
            hold      <= word;
            hold_err  <= oor;
            req_ready <= 1'b0;
          end
        end
        RD_WAIT: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) begin
            state     <= IDLE;
            rsp_valid <= 1'b1;
            rsp_rdata <= hold;
            rsp_err   <= hold_err;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of mem_ctrl in three configurations sharing one request bus.
module tb_mem_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [2:0] rst_n = 3'b000;
  logic req_valid = 1'b0, req_we = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic [1:0] req_be = '0;
  logic [2:0] rdy, vld, err, bsy;
  logic [15:0] rdata [3];
  int cur, n_chk, n_pass, tries, lat, v1, v2;
  mem_ctrl #(.RD_LAT(3)) u_l3 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid), .req_ready(rdy[0]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(vld[0]),
    .rsp_rdata(rdata[0]), .rsp_err(err[0]), .busy(bsy[0]));
  mem_ctrl #(.RD_LAT(1), .CLEAR_ON_RESET(0)) u_l1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid), .req_ready(rdy[1]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(vld[1]),
    .rsp_rdata(rdata[1]), .rsp_err(err[1]), .busy(bsy[1]));
  mem_ctrl #(.RD_LAT(4), .DEPTH(16)) u_l4 (
    .clk(clk), .rst_n(rst_n[2]), .req_valid(req_valid), .req_ready(rdy[2]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(vld[2]),
    .rsp_rdata(rdata[2]), .rsp_err(err[2]), .busy(bsy[2]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic we, input logic [15:0] a, input logic [15:0] d,
                      input logic [1:0] be, output int t);
    logic ok;
    req_we = we; req_addr = a; req_wdata = d; req_be = be; req_valid = 1'b1;
    t = 0; ok = 1'b0;
    while (!ok && t < 20) begin
      ok = rdy[cur];
      tick;
      t++;
    end
    req_valid = 1'b0;
    chk("accept", ok, 1'b1);
  endtask
  task automatic get_rsp(output int l);
    l = 1;
    while (!vld[cur] && l < 10) begin
      tick;
      l++;
    end
  endtask
  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be,
                    input logic e, input string tag);
    int t;
    send(1'b1, a, d, be, t);
    chk({tag, "_vld"}, vld[cur], 1'b1);
    chk({tag, "_err"}, err[cur], e);
  endtask
  task automatic rd(input logic [15:0] a, input logic [15:0] d, input logic e, input int l,
                    input string tag);
    int t, n;
    send(1'b0, a, 16'h0, 2'b00, t);
    get_rsp(n);
    chk({tag, "_lat"}, n, l);
    chk({tag, "_data"}, rdata[cur], d);
    chk({tag, "_err"}, err[cur], e);
  endtask
  // releases reset on cur and follows the clear; a write is offered throughout and must be ignored
  task automatic clear_len(input int depth, output int vcnt);
    int at, hi;
    at = -1; hi = 0; vcnt = 0;
    rst_n[cur] = 1'b1;
    req_we = 1'b1; req_addr = 16'h4; req_wdata = 16'hBEEF; req_be = 2'b11; req_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick;
      vcnt += int'(vld[cur]);
      if (bsy[cur]) hi++;
      if (rdy[cur]) begin
        at = i;
        break;
      end
    end
    req_valid = 1'b0;
    chk("clear_ready_edge", at, depth - 1);
    chk("clear_busy_cycles", hi, depth - 1);
    chk("clear_busy_done", bsy[cur], 1'b0);
  endtask
  initial begin
    n_chk = 0; n_pass = 0;
    cur = 0;
    tick; tick;
    chk("rst_ready", rdy[0], 1'b0);
    chk("rst_valid", vld[0], 1'b0);
    chk("rst_rdata", rdata[0], 16'h0);
    chk("rst_err", err[0], 1'b0);
    chk("rst_busy", bsy[0], 1'b1);
    clear_len(256, v1);
    chk("clear_no_rsp", v1, 0);
    rd(16'd0, 16'h0, 1'b0, 3, "clr0");
    rd(16'd17, 16'h0, 1'b0, 3, "clr17");
    rd(16'd255, 16'h0, 1'b0, 3, "clr255");
    rd(16'd4, 16'h0, 1'b0, 3, "clr_ignored_wr");
    wr(16'd5, 16'hABCD, 2'b11, 1'b0, "be_full");
    wr(16'd5, 16'h1234, 2'b01, 1'b0, "be_low");
    rd(16'd5, 16'hAB34, 1'b0, 3, "be_rd");
    wr(16'd5, 16'hFFFF, 2'b00, 1'b0, "be_none");
    rd(16'd5, 16'hAB34, 1'b0, 3, "be_none_rd");
    wr(16'd2, 16'h00FF, 2'b11, 1'b0, "lat_wr");
    send(1'b0, 16'd2, 16'h0, 2'b00, tries);
    chk("lat_c1_ready", rdy[0], 1'b0);
    chk("lat_c1_valid", vld[0], 1'b0);
    tick;
    chk("lat_c2_ready", rdy[0], 1'b0);
    chk("lat_c2_valid", vld[0], 1'b0);
    tick;
    chk("lat_c3_valid", vld[0], 1'b1);
    chk("lat_c3_ready", rdy[0], 1'b1);
    chk("lat_c3_data", rdata[0], 16'h00FF);
    send(1'b0, 16'd5, 16'h0, 2'b00, tries);
    chk("rdr_tries", tries, 1);
    chk("rdr_pulse", vld[0], 1'b0);
    get_rsp(lat);
    chk("rdr_lat", lat, 3);
    chk("rdr_data", rdata[0], 16'hAB34);
    wr(16'd0, 16'h1111, 2'b11, 1'b0, "err_pre");
    wr(16'h0100, 16'hFFFF, 2'b11, 1'b1, "err_wr");
    rd(16'd0, 16'h1111, 1'b0, 3, "err_keep");
    rd(16'h0100, 16'h0, 1'b1, 3, "err_rd");
    tick;
    chk("err_drop_valid", vld[0], 1'b0);
    chk("err_drop_err", err[0], 1'b0);
    cur = 1;
    rst_n[1] = 1'b0;
    tick; tick;
    chk("nc_rst_busy", bsy[1], 1'b0);
    chk("nc_rst_ready", rdy[1], 1'b0);
    rst_n[1] = 1'b1;
    tick;
    chk("nc_ready", rdy[1], 1'b1);
    req_we = 1'b1; req_addr = 16'd9; req_wdata = 16'h5555; req_be = 2'b11; req_valid = 1'b1;
    tick;
    chk("b2b_wr_valid", vld[1], 1'b1);
    chk("b2b_wr_err", err[1], 1'b0);
    chk("b2b_wr_ready", rdy[1], 1'b1);
    req_we = 1'b0;
    tick;
    req_valid = 1'b0;
    chk("b2b_rd_valid", vld[1], 1'b1);
    chk("b2b_rd_data", rdata[1], 16'h5555);
    chk("b2b_rd_ready", rdy[1], 1'b1);
    tick;
    chk("b2b_idle_valid", vld[1], 1'b0);
    cur = 2;
    rst_n[2] = 1'b0;
    tick; tick;
    clear_len(16, v1);
    wr(16'd3, 16'h7777, 2'b11, 1'b0, "ab_wr");
    rd(16'd3, 16'h7777, 1'b0, 4, "ab_rd");
    send(1'b0, 16'd3, 16'h0, 2'b00, tries);
    tick;
    rst_n[2] = 1'b0;
    tick;
    chk("ab_rst_valid", vld[2], 1'b0);
    chk("ab_rst_ready", rdy[2], 1'b0);
    chk("ab_rst_rdata", rdata[2], 16'h0);
    chk("ab_rst_err", err[2], 1'b0);
    chk("ab_rst_busy", bsy[2], 1'b1);
    v1 = int'(vld[2]);
    tick;
    v1 += int'(vld[2]);
    clear_len(16, v2);
    chk("ab_no_rsp", v1 + v2, 0);
    rd(16'd3, 16'h0, 1'b0, 4, "ab_recleared");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
